line_burst_mem: RTL and testbench
=================================

Name: line_burst_mem

Overview:
- Parametrised main-memory model for the cache benchmark. It serves whole cache lines instead of single words.
- Adds a fixed, configurable access latency and a request/grant handshake. This lets the cache controller see realistic miss penalties.
- Sits behind the cache as its only backing store. Contents are preloaded from a hex file so benchmark data is available at time zero.

Parameters:
- LINE_ADDR_LEN, 3: log2 of words per line; WORDS = 2^LINE_ADDR_LEN.
- MEM_ADDR_LEN, 8: line-address width; depth = 2^MEM_ADDR_LEN lines, total words = 2^(MEM_ADDR_LEN+LINE_ADDR_LEN).
- WAIT_CYCLES, 50: idle latency cycles before the word transfer starts. 0 is legal.
- INIT_FILE, "": $readmemh image. An empty string means the array is not initialised (X in simulation).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- rd_req  input  1  line read request; level, held until gnt.
- wr_req  input  1  line write request; level, held until gnt.
- addr  input  MEM_ADDR_LEN  line address; sampled only on acceptance.
- wr_line  input  32*WORDS  write data; word k at bits [32k+31:32k]; sampled only on acceptance.
- rd_line  output  32*WORDS  read data; valid in the gnt cycle, held until the next read completes.
- gnt  output  1  one-cycle completion pulse.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: state IDLE, gnt=0, busy=0, rd_line=0, counters 0. Memory array contents are not touched by reset.
- States: IDLE -> WAIT -> XFER -> DONE -> IDLE.
- IDLE:
  - On a clock edge with wr_req=1, accept a write. Otherwise, with rd_req=1, accept a read.
  - On acceptance, latch addr, op and wr_line; load wait counter with WAIT_CYCLES.
  - If WAIT_CYCLES=0, go directly to XFER; otherwise go to WAIT.
- WAIT: decrement the counter each cycle. Move to XFER on the edge where the counter is 1.
- XFER: word index k runs 0..WORDS-1, one word per cycle, through a single-port synchronous word array with 1-cycle read latency.
  - Write: store word k of the latched line at {addr,k}.
  - Read: issue {addr,k}; capture the returned word into line buffer slot k on the following cycle.
  - After k=WORDS-1, go to DONE. A read takes one extra XFER cycle to drain the last word.
- DONE: gnt=1 for exactly one cycle. On a read, rd_line <= line buffer at the same edge that enters DONE. Next state is IDLE.
- Latency from the acceptance edge to the gnt-high cycle:
  - write: WAIT_CYCLES + WORDS + 1 cycles.
  - read: WAIT_CYCLES + WORDS + 2 cycles.
  - This is fixed and independent of data.
- Requester drops its request on the edge that ends the gnt cycle. IDLE samples again on the next edge, so back-to-back ops are separated by exactly one IDLE cycle.
- Simultaneous rd_req and wr_req: write is served first. The read stays pending and is accepted in the next IDLE cycle. This covers write-back-then-refill.
- Request dropped mid-operation: the operation still completes and gnt still pulses. No abort.
- Request or addr changing after acceptance: ignored.
- Address wrap: none. Line addresses cover the whole array exactly; k never carries into addr.
- rst mid-operation: return to IDLE immediately; gnt=0, rd_line=0.
  - Words already written stay written; the line may be partially written. This is accepted behaviour.
  - No gnt is issued for the aborted op.
- rd_line is never updated by writes. A read of a just-written line returns the new data.

Decomposition:
- Package mem_pkg holds:
  - state enum {IDLE, WAIT, XFER, DONE};
  - word_t (32-bit);
  - localparam helpers for WORDS and word-address width.
- One sub-module, mem_word_array: single-port synchronous RAM.
  - Parameters: address width and INIT_FILE.
  - Ports: clk, addr, we, wdata, rdata.
  - Registered read (1 cycle), no reset on data, $readmemh in initial when INIT_FILE is non-empty.
- The top holds the FSM, counters and line buffer.

Test Plan (LINE_ADDR_LEN=3, MEM_ADDR_LEN=8, WAIT_CYCLES=4, INIT_FILE with word i = i+0x100):
- Read line 0x05 -> gnt high exactly 14 cycles after acceptance; rd_line words 0..7 = 0x128..0x12F; busy high throughout.
- Write line 0x10 with words 0xDEAD0000+k, then read 0x10 -> gnt after 13 cycles for the write, 14 for the read; read returns 0xDEAD0000..0xDEAD0007.
- rd_req and wr_req asserted together, both line 0x20 -> write granted first; read accepted one IDLE cycle after the write's gnt; read returns the written data; two gnt pulses total.
- WAIT_CYCLES=0 build, read line 0xFF -> gnt after 10 cycles; words = 0x8F8..0x8FF (last line, no wrap).
- rst pulsed in WAIT during a write to line 0x30 -> gnt never pulses, busy=0 and rd_line=0 next cycle; subsequent read of 0x30 returns the original 0x280..0x287.
- rd_req dropped two cycles after acceptance of line 0x01 -> gnt still pulses at cycle 14 with 0x108..0x10F; no new op started.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and size helpers for the line-burst main-memory model.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
  typedef logic [31:0] word_t;

  localparam int WORD_W = 32;

  function automatic int words(input int line_addr_len);
    return 1 << line_addr_len;
  endfunction

  function automatic int word_addr_w(input int line_addr_len, input int mem_addr_len);
    return line_addr_len + mem_addr_len;
  endfunction
endpackage

// File: rtl/mem_word_array.sv
// Single-port word RAM: registered read-first output, no reset on contents.
module mem_word_array
  import mem_pkg::*;
#(
  parameter int    ADDR_W    = 11,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  word_t             wdata,
  output word_t             rdata
);
  word_t mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/line_burst_mem.sv
// Line-granular main memory: fixed idle latency, then one word per cycle, then a gnt pulse.
module line_burst_mem
  import mem_pkg::*;
#(
  parameter int    LINE_ADDR_LEN = 3,
  parameter int    MEM_ADDR_LEN  = 8,
  parameter int    WAIT_CYCLES   = 50,
  parameter string INIT_FILE     = ""
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rd_req,
  input  logic                              wr_req,
  input  logic [MEM_ADDR_LEN-1:0]           addr,
  input  logic [32*(2**LINE_ADDR_LEN)-1:0]  wr_line,
  output logic [32*(2**LINE_ADDR_LEN)-1:0]  rd_line,
  output logic                              gnt,
  output logic                              busy
);
  localparam int WORDS = words(LINE_ADDR_LEN);
  localparam int AW    = word_addr_w(LINE_ADDR_LEN, MEM_ADDR_LEN);
  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [LINE_ADDR_LEN:0] K_LAST  = (LINE_ADDR_LEN+1)'(WORDS - 1);
  localparam logic [LINE_ADDR_LEN:0] K_DRAIN = (LINE_ADDR_LEN+1)'(WORDS);

  state_t                    state;
  logic                      op_wr;
  logic [MEM_ADDR_LEN-1:0]   line_addr;
  logic [CNT_W-1:0]          cnt;
  logic [LINE_ADDR_LEN:0]    k;
  logic [LINE_ADDR_LEN:0]    km1;
  word_t [WORDS-1:0]         wbuf, rbuf, rbuf_next;
  word_t                     ram_rdata;
  logic                      ram_we;
  logic [AW-1:0]             ram_addr;

  assign km1      = k - 1'b1;
  assign ram_we   = (state == XFER) && op_wr;
  assign ram_addr = {line_addr, k[LINE_ADDR_LEN-1:0]};

  // Read data lags the issued address by one cycle, so slot k-1 fills while k is issued.
  always_comb begin
    rbuf_next = rbuf;
    if (state == XFER && !op_wr && k != '0)
      rbuf_next[km1[LINE_ADDR_LEN-1:0]] = ram_rdata;
  end

  mem_word_array #(.ADDR_W(AW), .INIT_FILE(INIT_FILE)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (wbuf[k[LINE_ADDR_LEN-1:0]]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      busy      <= 1'b0;
      rd_line   <= '0;
      cnt       <= '0;
      k         <= '0;
      op_wr     <= 1'b0;
      line_addr <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
    end else begin
      gnt <= 1'b0;
      case (state)
        IDLE: if (wr_req || rd_req) begin
          op_wr     <= wr_req;
          line_addr <= addr;
          wbuf      <= wr_line;
          cnt       <= CNT_W'(WAIT_CYCLES);
          k         <= '0;
          busy      <= 1'b1;
          state     <= (WAIT_CYCLES == 0) ? XFER : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= XFER;
        end
        XFER: begin
          k <= k + 1'b1;
          if (op_wr) begin
            if (k == K_LAST) begin
              state <= DONE;
              gnt   <= 1'b1;
            end
          end else begin
            rbuf <= rbuf_next;
            if (k == K_DRAIN) begin
              state   <= DONE;
              gnt     <= 1'b1;
              rd_line <= rbuf_next;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_burst_mem.sv
// Bench for line_burst_mem: vector table plus hand sequences, gnt checked against a scoreboard.
module tb_line_burst_mem;
  localparam int LAT_WR = 4 + 8 + 1;
  localparam int LAT_RD = 4 + 8 + 2;

  typedef struct {
    logic        rd;
    int          cyc;
    logic [255:0] line;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [31:0] base;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rd_req, wr_req, rd_req0, wr_req0;
  logic [7:0] addr;
  logic [255:0] wr_line, rd_line, rd_line0;
  logic gnt, busy, gnt0, busy0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_cnt = 0;
  exp_t sb[$];
  vec_t vecs[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_burst_mem #(.LINE_ADDR_LEN(3), .MEM_ADDR_LEN(8), .WAIT_CYCLES(4), .INIT_FILE("")) u_a (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
    .wr_line(wr_line), .rd_line(rd_line), .gnt(gnt), .busy(busy)
  );

  line_burst_mem #(.LINE_ADDR_LEN(3), .MEM_ADDR_LEN(8), .WAIT_CYCLES(0), .INIT_FILE("")) u_b (
    .clk(clk), .rst(rst), .rd_req(rd_req0), .wr_req(wr_req0), .addr(addr),
    .wr_line(wr_line), .rd_line(rd_line0), .gnt(gnt0), .busy(busy0)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  // Every gnt pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && gnt) begin
      exp_t e;
      gnt_cnt++;
      chk("gnt_expected", 256'(sb.size() != 0), 256'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("gnt_cycle", 256'(cyc), 256'(e.cyc));
        if (e.rd) chk("rd_line", rd_line, e.line);
      end
    end
  end

  // Starts at the accepting edge, then watches for gnt with busy required high throughout.
  task automatic wait_gnt(output logic got, output logic bok);
    got = 1'b0;
    bok = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) bok = 1'b0;
      if (gnt) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic op(input logic wr, input logic [7:0] a, input logic [31:0] base);
    logic got, bok;
    @(posedge clk); #1;
    sb.push_back('{rd: !wr, cyc: cyc + (wr ? LAT_WR : LAT_RD), line: mk_line(base)});
    addr    = a;
    wr_line = wr ? mk_line(base) : '0;
    wr_req  = wr;
    rd_req  = !wr;
    wait_gnt(got, bok);
    chk("gnt_seen", 256'(got), 256'(1));
    chk("busy_held", 256'(bok), 256'(1));
    @(posedge clk); #1;
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  initial begin
    logic got, bok;
    int c0, g0;

    for (int i = 0; i < 2048; i++) begin
      u_a.u_ram.mem[i] = 32'(i) + 32'h100;
      u_b.u_ram.mem[i] = 32'(i) + 32'h100;
    end
    vecs[0] = '{wr: 1'b0, a: 8'h05, base: 32'h128};
    vecs[1] = '{wr: 1'b1, a: 8'h10, base: 32'hDEAD0000};
    vecs[2] = '{wr: 1'b0, a: 8'h10, base: 32'hDEAD0000};
    vecs[3] = '{wr: 1'b0, a: 8'hFF, base: 32'h8F8};
    vecs[4] = '{wr: 1'b0, a: 8'h00, base: 32'h100};

    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; rd_req0 = 1'b0; wr_req0 = 1'b0;
    addr = '0; wr_line = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_gnt", 256'(gnt), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_rd_line", rd_line, '0);
    chk("rst_rd_line_b", rd_line0, '0);

    for (int v = 0; v < 5; v++) op(vecs[v].wr, vecs[v].a, vecs[v].base);

    // Write and read raised together: write first, read one IDLE cycle after its gnt.
    @(posedge clk); #1;
    c0 = cyc;
    g0 = gnt_cnt;
    sb.push_back('{rd: 1'b0, cyc: c0 + LAT_WR, line: '0});
    sb.push_back('{rd: 1'b1, cyc: c0 + LAT_WR + 1 + LAT_RD, line: mk_line(32'hBEEF0000)});
    addr = 8'h20; wr_line = mk_line(32'hBEEF0000); wr_req = 1'b1; rd_req = 1'b1;
    wait_gnt(got, bok);
    chk("both_wr_gnt", 256'(got), 256'(1));
    @(posedge clk); #1 wr_req = 1'b0;
    wait_gnt(got, bok);
    chk("both_rd_gnt", 256'(got), 256'(1));
    @(posedge clk); #1 rd_req = 1'b0;
    repeat (3) @(posedge clk);
    chk("both_two_gnts", 256'(gnt_cnt - g0), 256'(2));

    // Reset while a write to 0x30 sits in WAIT: no gnt, outputs cleared, line untouched.
    @(posedge clk); #1;
    addr = 8'h30; wr_line = mk_line(32'h55550000); wr_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1; wr_req = 1'b0;
    @(negedge clk);
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_gnt", 256'(gnt), 256'(0));
    chk("abort_rd_line", rd_line, '0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    op(1'b0, 8'h30, 32'h280);

    // Request withdrawn two cycles after acceptance still completes exactly once.
    @(posedge clk); #1;
    sb.push_back('{rd: 1'b1, cyc: cyc + LAT_RD, line: mk_line(32'h108)});
    addr = 8'h01; rd_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1 rd_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt) begin
        got = 1'b1;
        break;
      end
    end
    chk("drop_gnt", 256'(got), 256'(1));
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drop_no_new_op", 256'(busy), 256'(0));

    // Zero-wait instance, last line in the array.
    @(posedge clk); #1;
    c0 = cyc;
    addr = 8'hFF; rd_req0 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt0) begin
        got = 1'b1;
        break;
      end
    end
    chk("b_gnt", 256'(got), 256'(1));
    chk("b_lat", 256'(cyc), 256'(c0 + 8 + 2));
    chk("b_rd_line", rd_line0, mk_line(32'h8F8));
    @(posedge clk); #1 rd_req0 = 1'b0;

    repeat (5) @(posedge clk);
    chk("sb_empty", 256'(sb.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
